pipelined_branch_alu: RTL and testbench
=======================================

# pipelined_branch_alu

Parametrised, registered successor to the combinational branch/ALU equator in the execute stage of the 5-stage pipeline. Accepts one operation per cycle over a valid/ready handshake and returns a 2×WIDTH result with flags one cycle later. Also returns a branch-taken decision evaluated on the same operation's flags. An optional iterative multiplier adds a multi-cycle op under a state machine.

## Interface
- WIDTH, 16, operand width in bits (≥4)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready
- a, b  in  WIDTH  operands
- op  in  3  000 ADD, 001 SUB, 010 MOVE, 011 SWAP, 100 AND, 101 OR, 110 CMP, 111 MUL/OR
- cond  in  3  000 never, 001 always, 010 EQ, 011 NE, 100 LT, 101 GE, 110 LTU, 111 GEU
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  downstream consumes when out_valid && out_ready
- result  out  2×WIDTH  {hi, lo}
- zero, negative, overflow, carry  out  1 each  flags
- branch_taken  out  1  cond evaluated on this op's flags
- busy  out  1  multiplier iterating

## Operation
- lo: ADD a+b; SUB/CMP a−b; MOVE b; SWAP b; AND a&b; OR a|b. hi = 0, except SWAP (hi = a) and MUL (hi:lo = unsigned a×b).
- Arithmetic mod 2^WIDTH. carry = carry-out for ADD; borrow (a<b unsigned) for SUB/CMP; 0 otherwise.
- overflow = signed overflow for ADD/SUB/CMP; 0 otherwise. negative = lo[WIDTH−1] (MUL: hi[WIDTH−1]). zero = (lo==0) (MUL: full product == 0).
- CMP sets flags and result as SUB; pipeline ignores result.
- cond: EQ=zero, NE=!zero, LT=negative^overflow, GE=!(negative^overflow), LTU=carry, GEU=!carry.
- FSM states: IDLE (output empty), FULL (output valid), MUL (iterating).
- IDLE: accept → FULL (single-cycle op) or MUL.
- FULL: out_ready && accept → FULL (new result) or MUL; out_ready with no accept → IDLE; !out_ready → hold.
- MUL: WIDTH iterations, then FULL.
- in_ready = (IDLE) || (FULL && out_ready). Low in MUL and while FULL is stalled.
- All outputs hold stable while out_valid && !out_ready.
- Reset: state IDLE; out_valid, result, flags, branch_taken, busy = 0; in_ready = 1 after release. Reset mid-MUL aborts; no partial result emitted.

## Timing
- Single-cycle op accepted at edge N → out_valid, result, flags valid from N+1. Throughput 1/cycle with out_ready held high.
- MUL accepted at N → busy high N+1..N+WIDTH; out_valid at N+WIDTH+1.
- in_ready is combinational from state and out_ready. No combinational path from a, b, op or cond to any output.

## Configuration
- PIPELINED_BRANCH_ALU_MUL_EN defined: op 111 = MUL; MUL state and multiplier sub-module present.
- Undefined: op 111 = OR (legacy default); MUL state absent; busy tied 0; all ops single-cycle.

## Structure
- Package alu_pkg: op encoding constants, cond encoding constants, FSM state typedef, flag struct typedef.
- One sub-module: seq_shift_add_mul (WIDTH-parametrised shift-add, start/done, WIDTH cycles), instantiated only under the macro.

## Test plan
- WIDTH=16, ADD 0x7FFF+0x0001, cond LT → result 0x00008000, overflow=1, negative=1, zero=0, carry=0, branch_taken=0.
- SUB 0x0005−0x0005, cond EQ → result 0, zero=1, carry=0, branch_taken=1. CMP 0x0003 vs 0x0005, cond LTU → carry=1, taken=1.
- SWAP a=0x1234, b=0xABCD → result 0x1234ABCD, flags computed from lo 0xABCD (negative=1).
- Back-to-back ADDs with out_ready=0 for 2 cycles → in_ready=0, result stable. A new op is accepted in the cycle out_ready rises, and its result appears the next cycle.
- With macro: MUL 0xFFFF×0xFFFF → result 0xFFFE0001 at N+17, busy high 16 cycles, in_ready low throughout. Without macro: same op → 0x0000FFFF at N+1.
- Assert rst_n low on cycle 5 of a MUL → out_valid=0, busy=0 immediately. After release, in_ready=1 and the next ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings, FSM state and flag types for the registered branch/ALU.
// Optional multiplier is enabled by defining PIPELINED_BRANCH_ALU_MUL_EN.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MOVE = 3'b010;
  localparam logic [2:0] OP_SWAP = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_CMP  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  localparam logic [2:0] COND_NEVER  = 3'b000;
  localparam logic [2:0] COND_ALWAYS = 3'b001;
  localparam logic [2:0] COND_EQ     = 3'b010;
  localparam logic [2:0] COND_NE     = 3'b011;
  localparam logic [2:0] COND_LT     = 3'b100;
  localparam logic [2:0] COND_GE     = 3'b101;
  localparam logic [2:0] COND_LTU    = 3'b110;
  localparam logic [2:0] COND_GEU    = 3'b111;

`ifdef PIPELINED_BRANCH_ALU_MUL_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FULL = 2'd1, S_MUL = 2'd2} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FULL = 2'd1} state_e;
`endif

  typedef struct packed {
    logic zero;
    logic negative;
    logic overflow;
    logic carry;
  } flags_t;

  function automatic logic eval_cond(input logic [2:0] c, input flags_t f);
    logic taken;
    case (c)
      COND_NEVER:  taken = 1'b0;
      COND_ALWAYS: taken = 1'b1;
      COND_EQ:     taken = f.zero;
      COND_NE:     taken = !f.zero;
      COND_LT:     taken = f.negative ^ f.overflow;
      COND_GE:     taken = !(f.negative ^ f.overflow);
      COND_LTU:    taken = f.carry;
      default:     taken = !f.carry;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/seq_shift_add_mul.sv
// Iterative unsigned shift-add multiplier: start loads operands, one partial
// product per cycle, o_done/o_product valid combinationally on the last step.
module seq_shift_add_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CW = $clog2(WIDTH);

  logic              r_run;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH:0]    w_sum;
  logic [2*WIDTH-1:0] w_prod_next;

  // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
  assign w_sum       = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_prod_next = {w_sum, r_prod[WIDTH-1:1]};
  assign o_done      = r_run && (r_cnt == CW'(WIDTH - 1));
  assign o_product   = w_prod_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run   <= 1'b0;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_prod  <= '0;
    end else if (i_start) begin
      r_run   <= 1'b1;
      r_cnt   <= '0;
      r_mcand <= i_a;
      r_prod  <= {{WIDTH{1'b0}}, i_b};
    end else if (r_run) begin
      r_prod <= w_prod_next;
      r_cnt  <= r_cnt + 1'b1;
      if (o_done) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/pipelined_branch_alu.sv
// Registered execute-stage ALU with branch decision and valid/ready handshake.
// Define PIPELINED_BRANCH_ALU_MUL_EN to turn op 111 into a multi-cycle MUL.
module pipelined_branch_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
  input  logic [2:0]         cond,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               zero,
  output logic               negative,
  output logic               overflow,
  output logic               carry,
  output logic               branch_taken,
  output logic               busy,
  output state_e             dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; a stalled output (out_valid && !out_ready) freezes every output.
  state_e             r_state, w_next, w_load_state;
  logic               w_accept, w_is_mul;
  logic [2*WIDTH-1:0] r_result;
  flags_t             r_flags, w_flags;
  logic               r_taken, w_taken;
  logic [WIDTH:0]     w_sum, w_diff;
  logic [WIDTH-1:0]   w_lo, w_hi;

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_FULL) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == S_FULL);
  assign result    = r_result;
  assign zero      = r_flags.zero;
  assign negative  = r_flags.negative;
  assign overflow  = r_flags.overflow;
  assign carry     = r_flags.carry;
  assign branch_taken = r_taken;
  assign dbg_state = r_state;

  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    w_lo    = '0;
    w_hi    = '0;
    w_flags = '0;
    case (op)
      OP_ADD: begin
        w_lo             = w_sum[WIDTH-1:0];
        w_flags.carry    = w_sum[WIDTH];
        w_flags.overflow = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        w_lo             = w_diff[WIDTH-1:0];
        w_flags.carry    = w_diff[WIDTH];
        w_flags.overflow = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_MOVE: w_lo = b;
      OP_SWAP: begin
        w_lo = b;
        w_hi = a;
      end
      OP_AND:  w_lo = a & b;
      default: w_lo = a | b;
    endcase
    w_flags.negative = w_lo[WIDTH-1];
    w_flags.zero     = (w_lo == '0);
    w_taken          = eval_cond(cond, w_flags);
  end

`ifdef PIPELINED_BRANCH_ALU_MUL_EN
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_product;
  flags_t             w_mul_flags;
  logic [2:0]         r_cond;

  assign w_is_mul = (op == OP_MUL);
  assign busy     = (r_state == S_MUL);

  always_comb begin
    w_mul_flags          = '0;
    w_mul_flags.zero     = (w_product == '0);
    w_mul_flags.negative = w_product[2*WIDTH-1];
  end

  seq_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_accept && w_is_mul),
    .i_a       (a),
    .i_b       (b),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  // The branch condition must survive the iteration, so it is captured at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cond <= '0;
    else if (w_accept && w_is_mul) r_cond <= cond;
  end
`else
  assign w_is_mul = 1'b0;
  assign busy     = 1'b0;
`endif

  always_comb begin
`ifdef PIPELINED_BRANCH_ALU_MUL_EN
    w_load_state = w_is_mul ? S_MUL : S_FULL;
`else
    w_load_state = S_FULL;
`endif
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_load_state;
      S_FULL: if (out_ready) w_next = w_accept ? w_load_state : S_IDLE;
`ifdef PIPELINED_BRANCH_ALU_MUL_EN
      S_MUL:  if (w_mul_done) w_next = S_FULL;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_flags  <= '0;
      r_taken  <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_result <= {w_hi, w_lo};
      r_flags  <= w_flags;
      r_taken  <= w_taken;
    end
`ifdef PIPELINED_BRANCH_ALU_MUL_EN
    else if ((r_state == S_MUL) && w_mul_done) begin
      r_result <= w_product;
      r_flags  <= w_mul_flags;
      r_taken  <= eval_cond(r_cond, w_mul_flags);
    end
`endif
  end

endmodule

// File: tb/tb_pipelined_branch_alu.sv
// Directed bench for pipelined_branch_alu (WIDTH=16); covers the multiplier
// when PIPELINED_BRANCH_ALU_MUL_EN is defined, the legacy OR otherwise.
module tb_pipelined_branch_alu;
  import alu_pkg::*;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a, b;
  logic [2:0]     op, cond;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           zero, negative, overflow, carry;
  logic           branch_taken;
  logic           busy;
  state_e         dbg_state;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  pipelined_branch_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cond(cond), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .negative(negative),
    .overflow(overflow), .carry(carry), .branch_taken(branch_taken),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // driver: present one op, require acceptance on the next edge
  task automatic issue(input logic [2:0] i_op, input logic [W-1:0] i_a,
                       input logic [W-1:0] i_b, input logic [2:0] i_cond,
                       input logic push, input logic [2*W-1:0] exp_res);
    op = i_op; a = i_a; b = i_b; cond = i_cond; in_valid = 1'b1;
    #1;
    chk("in_ready_before_issue", 64'(in_ready), 64'd1);
    if (push) exp_q.push_back(exp_res);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // scoreboard: result popped from the expected queue, flags as {z,n,v,c}
  task automatic check_out(input string tag, input logic [3:0] exp_flags, input logic exp_taken);
    logic [2*W-1:0] exp_res;
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd1);
    end else begin
      exp_res = exp_q.pop_front();
      chk({tag, "_result"}, 64'(result), 64'(exp_res));
    end
    chk({tag, "_flags"}, 64'({zero, negative, overflow, carry}), 64'(exp_flags));
    chk({tag, "_taken"}, 64'(branch_taken), 64'(exp_taken));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; cond = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'({zero, negative, overflow, carry}), 64'd0);
    chk("rst_taken", 64'(branch_taken), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_state", 64'(dbg_state), 64'(S_IDLE));

    out_ready = 1'b1;
    issue(OP_ADD, 16'h7FFF, 16'h0001, COND_LT, 1'b1, 32'h0000_8000);
    check_out("add_ovf", 4'b0110, 1'b0);
    issue(OP_SUB, 16'h0005, 16'h0005, COND_EQ, 1'b1, 32'h0000_0000);
    check_out("sub_eq", 4'b1000, 1'b1);
    issue(OP_CMP, 16'h0003, 16'h0005, COND_LTU, 1'b1, 32'h0000_FFFE);
    check_out("cmp_ltu", 4'b0101, 1'b1);
    issue(OP_SWAP, 16'h1234, 16'hABCD, COND_NEVER, 1'b1, 32'h1234_ABCD);
    check_out("swap", 4'b0100, 1'b0);
    issue(OP_AND, 16'hF0F0, 16'h3C3C, COND_GE, 1'b1, 32'h0000_3030);
    check_out("and_ge", 4'b0000, 1'b1);
    issue(OP_OR, 16'h00F0, 16'h0F00, COND_NE, 1'b1, 32'h0000_0FF0);
    check_out("or_ne", 4'b0000, 1'b1);
    issue(OP_MOVE, 16'hFFFF, 16'h0000, COND_EQ, 1'b1, 32'h0000_0000);
    check_out("move_zero", 4'b1000, 1'b1);
    issue(OP_ADD, 16'hFFFF, 16'h0001, COND_GEU, 1'b1, 32'h0000_0000);
    check_out("add_carry", 4'b1001, 1'b0);
    issue(OP_SUB, 16'h8000, 16'h0001, COND_LT, 1'b1, 32'h0000_7FFF);
    check_out("sub_ovf", 4'b0010, 1'b1);
    @(posedge clk); #1;
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    chk("drain_state", 64'(dbg_state), 64'(S_IDLE));

    // back-pressure: output held for two cycles, next op accepted as out_ready rises
    out_ready = 1'b0;
    issue(OP_ADD, 16'h0001, 16'h0002, COND_NEVER, 1'b1, 32'h0000_0003);
    check_out("stall_first", 4'b0000, 1'b0);
    op = OP_ADD; a = 16'h0010; b = 16'h0020; cond = COND_ALWAYS; in_valid = 1'b1;
    #1;
    chk("stall_in_ready_0", 64'(in_ready), 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_result_hold", 64'(result), 64'h0000_0003);
      chk("stall_valid_hold", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    exp_q.push_back(32'h0000_0030);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_out("stall_second", 4'b0000, 1'b1);
    @(posedge clk); #1;
    chk("stall_drain_valid", 64'(out_valid), 64'd0);

`ifdef PIPELINED_BRANCH_ALU_MUL_EN
    issue(OP_MUL, 16'hFFFF, 16'hFFFF, COND_ALWAYS, 1'b1, 32'hFFFE_0001);
    for (int i = 0; i < W; i++) begin
      chk("mul_busy", 64'(busy), 64'd1);
      chk("mul_in_ready", 64'(in_ready), 64'd0);
      chk("mul_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    check_out("mul", 4'b0100, 1'b1);
    chk("mul_busy_done", 64'(busy), 64'd0);
    @(posedge clk); #1;
    issue(OP_MUL, 16'h1234, 16'h0005, COND_ALWAYS, 1'b0, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("mul_abort_busy_before", 64'(busy), 64'd1);
`else
    issue(OP_MUL, 16'hFFFF, 16'hFFFF, COND_ALWAYS, 1'b1, 32'h0000_FFFF);
    check_out("legacy_or", 4'b0100, 1'b1);
    chk("legacy_busy", 64'(busy), 64'd0);
    issue(OP_ADD, 16'h0001, 16'h0001, COND_ALWAYS, 1'b0, 32'h0);
`endif

    // asynchronous abort: outputs clear without waiting for a clock edge
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    issue(OP_ADD, 16'h0002, 16'h0003, COND_GE, 1'b1, 32'h0000_0005);
    check_out("after_abort", 4'b0000, 1'b1);
    @(posedge clk); #1;
    chk("final_out_valid", 64'(out_valid), 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
